pkt_tx_sf_buffer: RTL and testbench

PKT_TX_SF_BUFFER -- requirements
Module: pkt_tx_sf_buffer

---
 rtl/pkt_tx_sf_buffer.sv | 126 ++++++++++++
 tb/tb_pkt_tx_sf_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_sf_buffer.sv
// pkt_tx_sf_buffer: store-and-forward TX buffer feeding a MAC TX FIFO.
// Packets become readable only once their eop is written; oversize or eop-less packets are rewound and dropped.
module pkt_tx_sf_buffer #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 512,
  localparam int MOD_W  = $clog2(DATA_W / 8),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic              in_val,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  input  logic [MOD_W-1:0]  in_mod,
  input  logic              pkt_tx_full,
  output logic              pkt_tx_val,
  output logic              pkt_tx_sop,
  output logic              pkt_tx_eop,
  output logic [DATA_W-1:0] pkt_tx_data,
  output logic [MOD_W-1:0]  pkt_tx_mod,
  output logic [AW:0]       stat_pkt_cnt,
  output logic              stat_drop_tog
);
  localparam int WW = DATA_W + MOD_W + 2;
  localparam logic [AW:0] INC  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_e;
  typedef enum logic {R_IDLE, R_PKT} rstate_e;

  logic [WW-1:0]     mem_q [DEPTH];
  wstate_e           wstate_q, wstate_d;
  rstate_e           rstate_q, rstate_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d, pkt_cnt_q, pkt_cnt_d, base;
  logic              drop_tog_q, drop_tog_d, val_q, val_d, sop_q, sop_d, eop_q, eop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic              we, commit, ovf, issue, rd_eop;
  logic [WW-1:0]     rd_word;

  // A sop always restarts at the last commit point, discarding any unfinished packet.
  always_comb begin
    base        = in_sop ? wr_commit_q : wr_ptr_q;
    ovf         = (base - rd_ptr_q) == FULL;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wstate_d    = wstate_q;
    drop_tog_d  = drop_tog_q;
    we          = 1'b0;
    commit      = 1'b0;
    if (in_val && (in_sop || wstate_q == W_PKT)) begin
      if (ovf) begin
        wr_ptr_d   = wr_commit_q;
        drop_tog_d = ~drop_tog_q;
        wstate_d   = in_eop ? W_IDLE : W_DROP;
      end else begin
        we          = 1'b1;
        commit      = in_eop;
        wr_ptr_d    = base + INC;
        wr_commit_d = in_eop ? base + INC : wr_commit_q;
        drop_tog_d  = drop_tog_q ^ (in_sop && wstate_q == W_PKT);
        wstate_d    = in_eop ? W_IDLE : W_PKT;
      end
    end else if (in_val && in_eop) begin
      wstate_d = W_IDLE;
    end
  end

  always_comb begin
    rd_word   = mem_q[rd_ptr_q[AW-1:0]];
    rd_eop    = rd_word[WW-2];
    issue     = (rstate_q == R_PKT || pkt_cnt_q != '0) && rd_ptr_q != wr_commit_q && !pkt_tx_full;
    rd_ptr_d  = issue ? rd_ptr_q + INC : rd_ptr_q;
    rstate_d  = issue ? (rd_eop ? R_IDLE : R_PKT) : rstate_q;
    val_d     = issue;
    sop_d     = issue && rd_word[WW-1];
    eop_d     = issue && rd_eop;
    data_d    = issue ? rd_word[DATA_W-1:0] : data_q;
    mod_d     = issue ? rd_word[DATA_W +: MOD_W] : mod_q;
    pkt_cnt_d = pkt_cnt_q + (commit ? INC : '0) - (eop_d ? INC : '0);
  end

  always_ff @(posedge clk_156m25) begin
    if (we) mem_q[base[AW-1:0]] <= {in_sop, in_eop, in_mod, in_data};
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      wstate_q    <= W_IDLE;
      rstate_q    <= R_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
      drop_tog_q  <= 1'b0;
      val_q       <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
      mod_q       <= '0;
    end else begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_tog_q  <= drop_tog_d;
      val_q       <= val_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      data_q      <= data_d;
      mod_q       <= mod_d;
    end
  end

  assign pkt_tx_val    = val_q;
  assign pkt_tx_sop    = sop_q;
  assign pkt_tx_eop    = eop_q;
  assign pkt_tx_data   = data_q;
  assign pkt_tx_mod    = mod_q;
  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_drop_tog = drop_tog_q;
endmodule

// File: tb/tb_pkt_tx_sf_buffer.sv
// tb_pkt_tx_sf_buffer: packet-level scoreboard bench for pkt_tx_sf_buffer.
// Committed packets are queued as expected words; a monitor pops one per presented word.
module tb_pkt_tx_sf_buffer;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int MOD_W  = 3;
  localparam int AW     = 4;
  localparam int WW     = DATA_W + MOD_W + 2;
  typedef logic [WW-1:0] word_t;

  logic              clk_156m25 = 1'b0;
  logic              reset_156m25_n = 1'b0;
  logic              in_val = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [MOD_W-1:0]  in_mod = '0;
  logic              pkt_tx_full = 1'b0;
  logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [DATA_W-1:0] pkt_tx_data;
  logic [MOD_W-1:0]  pkt_tx_mod;
  logic [AW:0]       stat_pkt_cnt;
  logic              stat_drop_tog;

  word_t exp_q[$];
  word_t exp_w;
  int    n_chk = 0, n_fail = 0, drops = 0;
  bit    full_force = 1'b0, rand_full = 1'b0, gaps = 1'b0, prev_full = 1'b0;

  pkt_tx_sf_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_156m25(clk_156m25), .reset_156m25_n(reset_156m25_n),
    .in_val(in_val), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .in_mod(in_mod),
    .pkt_tx_full(pkt_tx_full), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_data(pkt_tx_data), .pkt_tx_mod(pkt_tx_mod),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_tog(stat_drop_tog)
  );

  always #5 clk_156m25 = ~clk_156m25;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT did not respond within the cycle budget", name);
  endtask

  // Backpressure is applied 2 time units after the edge so directed code can set full_force at edge+1.
  initial forever begin
    @(posedge clk_156m25);
    #2;
    pkt_tx_full = rand_full ? ($urandom_range(3) == 0) : full_force;
  end

  always @(negedge clk_156m25) begin
    if (reset_156m25_n) begin
      if (prev_full) check("full_gate", WW'(pkt_tx_val), WW'(0));
      if (pkt_tx_val) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected no word", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data});
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}, exp_w);
        end
      end else begin
        check("idle_flags", WW'({pkt_tx_sop, pkt_tx_eop}), WW'(0));
      end
    end
    prev_full <= pkt_tx_full;
  end

  task automatic drive(input word_t w);
    in_val = 1'b1;
    {in_sop, in_eop, in_mod, in_data} = w;
    @(posedge clk_156m25);
    #1;
    in_val = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    in_val = 1'b0;
    repeat (n) begin
      @(posedge clk_156m25);
      #1;
    end
  endtask

  // Reference model: a packet fits unless it is longer than an empty buffer; only committed packets are expected.
  task automatic send_pkt(input int len, input bit commit, input int eop_mod);
    word_t pk[$];
    int t = 0;
    while (exp_q.size() != 0 && exp_q.size() + len > DEPTH && t < 5000) begin
      @(posedge clk_156m25);
      #1;
      t++;
    end
    if (t == 5000) timeout("room");
    for (int i = 0; i < len; i++) begin
      logic s, e;
      logic [MOD_W-1:0] m;
      word_t w;
      s = (i == 0);
      e = commit && (i == len - 1);
      m = (e && eop_mod >= 0) ? MOD_W'(eop_mod) : MOD_W'($urandom);
      w = {s, e, m, $urandom, $urandom};
      pk.push_back(w);
      if (i > 0 && gaps && $urandom_range(3) == 0) idle(1);
      drive(w);
    end
    if (commit && len > DEPTH) drops++;
    else if (commit) foreach (pk[i]) exp_q.push_back(pk[i]);
  endtask

  task automatic wait_empty(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk_156m25);
      #1;
      t++;
    end
    if (exp_q.size() != 0) timeout(name);
    idle(3);
  endtask

  initial begin
    repeat (3) @(posedge clk_156m25);
    @(negedge clk_156m25);
    check("reset_val", WW'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop}), WW'(0));
    check("reset_dm", WW'({pkt_tx_mod, pkt_tx_data}), WW'(0));
    check("reset_cnt", WW'(stat_pkt_cnt), WW'(0));
    check("reset_tog", WW'(stat_drop_tog), WW'(0));
    @(posedge clk_156m25);
    #1;
    reset_156m25_n = 1'b1;
    idle(2);

    // Single 4-word packet: latency, back-to-back words and count profile.
    send_pkt(4, 1'b1, 3);
    @(negedge clk_156m25);
    check("cnt_commit", WW'(stat_pkt_cnt), WW'(1));
    check("lat_early", WW'(pkt_tx_val), WW'(0));
    @(negedge clk_156m25);
    check("lat_sop", WW'({pkt_tx_val, pkt_tx_sop}), WW'(2'b11));
    repeat (3) begin
      @(negedge clk_156m25);
      check("consec", WW'(pkt_tx_val), WW'(1));
    end
    check("cnt_eop", WW'(stat_pkt_cnt), WW'(0));
    @(negedge clk_156m25);
    check("post_eop", WW'(pkt_tx_val), WW'(0));
    wait_empty("drain_single");

    // Full held during a 10-word packet, then released.
    full_force = 1'b1;
    send_pkt(10, 1'b1, -1);
    idle(5);
    check("cnt_held", WW'(stat_pkt_cnt), WW'(1));
    full_force = 1'b0;
    wait_empty("drain_full");

    // Oversize packet then a short one.
    send_pkt(DEPTH + 1, 1'b1, -1);
    send_pkt(2, 1'b1, -1);
    wait_empty("drain_oversize");
    check("drop_oversize", WW'(stat_drop_tog), WW'(drops % 2));

    // Missing eop: A abandoned by B's sop.
    send_pkt(3, 1'b0, -1);
    drops++;
    send_pkt(5, 1'b1, -1);
    wait_empty("drain_abort");
    check("drop_abort", WW'(stat_drop_tog), WW'(drops % 2));

    // Commit of packet 2 on the same edge packet 1's eop issues.
    full_force = 1'b1;
    send_pkt(2, 1'b1, -1);
    idle(2);
    check("cnt_pre", WW'(stat_pkt_cnt), WW'(1));
    full_force = 1'b0;
    idle(1);
    send_pkt(1, 1'b1, -1);
    @(negedge clk_156m25);
    check("cnt_same_edge", WW'(stat_pkt_cnt), WW'(1));
    wait_empty("drain_same_edge");

    // Randomized traffic with backpressure, gaps, stray words and aborted packets.
    rand_full = 1'b1;
    gaps = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(9);
      if (r == 0) drive({1'b0, 1'($urandom_range(1)), MOD_W'($urandom), $urandom, $urandom});
      else if (r == 1) begin
        send_pkt($urandom_range(6, 1), 1'b0, -1);
        drops++;
        send_pkt($urandom_range(8, 1), 1'b1, -1);
      end else send_pkt($urandom_range(8, 1), 1'b1, -1);
      if ($urandom_range(3) == 0) idle($urandom_range(3));
    end
    rand_full = 1'b0;
    gaps = 1'b0;
    wait_empty("drain_random");
    check("drop_random", WW'(stat_drop_tog), WW'(drops % 2));
    check("cnt_random", WW'(stat_pkt_cnt), WW'(0));

    // Reset in the middle of an outgoing packet.
    send_pkt(8, 1'b1, -1);
    for (int t = 0; t < 50 && !pkt_tx_val; t++) @(negedge clk_156m25);
    if (!pkt_tx_val) timeout("reset_wait");
    #2;
    reset_156m25_n = 1'b0;
    #1;
    check("rst_async_val", WW'(pkt_tx_val), WW'(0));
    check("rst_async_cnt", WW'(stat_pkt_cnt), WW'(0));
    check("rst_async_tog", WW'(stat_drop_tog), WW'(0));
    exp_q.delete();
    drops = 0;
    repeat (2) @(posedge clk_156m25);
    #1;
    reset_156m25_n = 1'b1;
    idle(20);
    check("rst_cnt_after", WW'(stat_pkt_cnt), WW'(0));
    send_pkt(3, 1'b1, -1);
    wait_empty("drain_after_reset");
    check("rst_tog_after", WW'(stat_drop_tog), WW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
